// File: rtl/nic8_ctrl_pkg.sv
// Shared control definitions for the NIC8 fetch/execute sequencer.
// State encoding, instruction field positions and decode helpers.
package nic8_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET,
    FETCH,
    EXEC,
    PAUSE,
    HALT,
    FAULT
  } ctrlStateT;

  localparam logic [2:0] HALT_DEST  = 3'b111;
  localparam logic [2:0] IMM_SOURCE = 3'b000;

  localparam int FIELD_W  = 3;
  localparam int DEST_LSB = 4;
  localparam int SRC_LSB  = 0;

  function automatic logic isHaltInstr(
    input logic [7:0] ir
  );
    return ir[DEST_LSB +: FIELD_W] == HALT_DEST;
  endfunction

  function automatic logic isImmInstr(
    input logic [7:0] ir
  );
    return ir[SRC_LSB +: FIELD_W] == IMM_SOURCE;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags a timeout
// on the cycle that would exceed MAX_WAIT.
module mem_wait_timer #(
  parameter int MAX_WAIT = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic ready,
  output logic expired
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] waitCnt;

  always_ff @(posedge clk) begin
    if (reset || clear || ready) begin
      waitCnt <= '0;
    end else if (waitCnt != MAX_W) begin
      waitCnt <= waitCnt + 4'd1;
    end
  end

  // Already waited MAX_WAIT cycles and still not ready.
  assign expired = !ready && (waitCnt == MAX_W);

endmodule

// File: rtl/fetch_exec_seq.sv
// NIC8 fetch/execute sequencer with single-step and halt control.
// Define FETCH_EXEC_SEQ_WAIT_STATE_EN to honour memReady and timeout.
module fetch_exec_seq
  import nic8_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ir,
  input  logic        memReady,
  input  logic        stepMode,
  input  logic        stepReq,
  output logic        fetchIR,
  output logic        incPC,
  output logic        execEnable,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instrCount
);

  ctrlStateT state;
  ctrlStateT stateNext;

  logic rdy;
  logic retire;
  logic fetchI;
  logic incI;
  logic execI;
  logic haltI;
  logic haltOp;
  logic immOp;

  assign haltOp = isHaltInstr(ir);
  assign immOp  = isImmInstr(ir);

`ifdef FETCH_EXEC_SEQ_WAIT_STATE_EN
  logic waitActive;
  logic expired;
  logic faultI;
  logic timerClear;

  assign rdy = memReady;

  assign timerClear = !waitActive || (stateNext != state);

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) uTimer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timerClear),
    .ready  (rdy),
    .expired(expired)
  );
`else
  logic unusedMem;

  assign rdy       = 1'b1;
  assign unusedMem = memReady;
`endif

  always_comb begin
    stateNext = state;
    fetchI    = 1'b0;
    incI      = 1'b0;
    execI     = 1'b0;
    haltI     = 1'b0;
    retire    = 1'b0;
`ifdef FETCH_EXEC_SEQ_WAIT_STATE_EN
    waitActive = 1'b0;
    faultI     = 1'b0;
`endif
    unique case (state)
      RESET: stateNext = FETCH;
      FETCH: begin
        fetchI = 1'b1;
`ifdef FETCH_EXEC_SEQ_WAIT_STATE_EN
        waitActive = 1'b1;
`endif
        if (rdy) begin
          incI      = 1'b1;
          stateNext = EXEC;
        end
`ifdef FETCH_EXEC_SEQ_WAIT_STATE_EN
        else if (expired) begin
          stateNext = FAULT;
        end
`endif
      end
      EXEC: begin
        if (haltOp) begin
          retire    = 1'b1;
          stateNext = HALT;
        end else if (immOp && !rdy) begin
`ifdef FETCH_EXEC_SEQ_WAIT_STATE_EN
          waitActive = 1'b1;
          if (expired) begin
            stateNext = FAULT;
          end
`endif
        end else begin
          execI     = 1'b1;
          incI      = immOp;
          retire    = 1'b1;
          stateNext = stepMode ? PAUSE : FETCH;
        end
      end
      PAUSE: begin
        if (stepReq) begin
          stateNext = FETCH;
        end
      end
      HALT: begin
        haltI = 1'b1;
        if (stepReq) begin
          stateNext = FETCH;
        end
      end
`ifdef FETCH_EXEC_SEQ_WAIT_STATE_EN
      FAULT: faultI = 1'b1;
`endif
      default: stateNext = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instrCount <= '0;
    end else if (retire) begin
      instrCount <= instrCount + 16'd1;
    end
  end

  // Strobes are suppressed while reset is held so no partial pulse escapes.
  assign fetchIR    = fetchI && !reset;
  assign incPC      = incI && !reset;
  assign execEnable = execI && !reset;
  assign halted     = haltI;

`ifdef FETCH_EXEC_SEQ_WAIT_STATE_EN
  assign fault = faultI;
`else
  assign fault = 1'b0;
`endif

endmodule
